// File: rtl/kz_pkg.sv
// Shared definitions for the K_Z kernel datapath and its scheduler.
package kz_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_KZ_LATENCY = 20;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } kz_state_t;

endpackage

// File: rtl/kz_sched_if.sv
// Bundle of host control, point-memory, K_Z and result signals around kz_sched.
interface kz_sched_if #(
    parameter int DATA_WIDTH = kz_pkg::DEF_DATA_WIDTH,
    parameter int ADDR_W     = kz_pkg::DEF_ADDR_W,
    parameter int SUM_W      = 48
);

    logic                  start;
    logic [ADDR_W:0]       num_points;
    logic [DATA_WIDTH-1:0] query_x, query_y, query_z;
    logic                  busy;
    logic                  done;
    logic                  mem_rd_en;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0] mem_x, mem_y, mem_z;
    logic [DATA_WIDTH-1:0] kz_int_x, kz_int_y, kz_int_z;
    logic [DATA_WIDTH-1:0] kz_norm_x, kz_norm_y, kz_norm_z;
    logic [31:0]           kz_out;
    logic                  k_valid;
    logic [ADDR_W-1:0]     k_index;
    logic [31:0]           k_data;
    logic [SUM_W-1:0]      k_sum;

    modport slave (
        input  start, num_points, query_x, query_y, query_z,
        input  mem_x, mem_y, mem_z, kz_out,
        output busy, done, mem_rd_en, mem_addr,
        output kz_int_x, kz_int_y, kz_int_z,
        output kz_norm_x, kz_norm_y, kz_norm_z,
        output k_valid, k_index, k_data, k_sum
    );

    modport master (
        output start, num_points, query_x, query_y, query_z,
        output mem_x, mem_y, mem_z, kz_out,
        input  busy, done, mem_rd_en, mem_addr,
        input  kz_int_x, kz_int_y, kz_int_z,
        input  kz_norm_x, kz_norm_y, kz_norm_z,
        input  k_valid, k_index, k_data, k_sum
    );

endinterface

// File: rtl/kz_valid_pipe.sv
// Fixed-depth shift register tracking {valid, index} alongside the K_Z pipeline.
module kz_valid_pipe #(
    parameter int DEPTH = 22,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_index,
    output logic             pending,
    output logic             pre_valid,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_index
);

    logic [DEPTH-1:0] vld;
    logic [IDX_W-1:0] idx [DEPTH];

    // Index stages only move with a valid token so the last index stays visible after a run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                idx[j] <= '0;
            end
        end else begin
            vld <= {vld[DEPTH-2:0], in_valid};
            if (in_valid) begin
                idx[0] <= in_index;
            end
            for (int j = 1; j < DEPTH; j++) begin
                if (vld[j-1]) begin
                    idx[j] <= idx[j-1];
                end
            end
        end
    end

    assign pending   = |vld[DEPTH-2:0];
    assign pre_valid = vld[DEPTH-2];
    assign out_valid = vld[DEPTH-1];
    assign out_index = idx[DEPTH-1];

endmodule

// File: rtl/kz_sched.sv
// Streams stored points through K_Z for one query, tagging and summing each kernel result.
module kz_sched
    import kz_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int N_MAX      = 2 ** DEF_ADDR_W,
    parameter int KZ_LATENCY = DEF_KZ_LATENCY,
    parameter int SUM_W      = 48
) (
    input  logic      clk,
    input  logic      rst_n,
    kz_sched_if.slave bus
);

    localparam int              DEPTH  = KZ_LATENCY + 2;
    localparam logic [ADDR_W:0] NP_MAX = (ADDR_W + 1)'(N_MAX);

    kz_state_t             state, next_state;
    logic [ADDR_W-1:0]     cnt;
    logic [ADDR_W:0]       np_lat;
    logic [ADDR_W:0]       last_idx;
    logic                  accept;
    logic                  pending, pre_valid, out_valid;
    logic [ADDR_W-1:0]     out_index;
    logic [DATA_WIDTH-1:0] int_x, int_y, int_z;
    logic [DATA_WIDTH-1:0] norm_x, norm_y, norm_z;
    logic [31:0]           data_r;
    logic [SUM_W-1:0]      sum_r;

    assign accept   = (state == IDLE) && bus.start;
    assign last_idx = np_lat - (ADDR_W + 1)'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = (bus.num_points == '0) ? DONE : ISSUE;
            ISSUE:   if ({1'b0, cnt} == last_idx) next_state = DRAIN;
            DRAIN:   if (!pending && out_valid) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Out-of-range counts are clamped so a bad request cannot run past the memory.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            np_lat <= '0;
            int_x  <= '0;
            int_y  <= '0;
            int_z  <= '0;
            norm_x <= '0;
            norm_y <= '0;
            norm_z <= '0;
            data_r <= '0;
            sum_r  <= '0;
        end else begin
            if (bus.mem_rd_en) begin
                int_x <= bus.mem_x;
                int_y <= bus.mem_y;
                int_z <= bus.mem_z;
            end
            if (pre_valid) begin
                data_r <= bus.kz_out;
                sum_r  <= sum_r + {{(SUM_W - 32){bus.kz_out[31]}}, bus.kz_out};
            end
            if (accept) begin
                cnt    <= '0;
                np_lat <= (bus.num_points > NP_MAX) ? NP_MAX : bus.num_points;
                norm_x <= bus.query_x;
                norm_y <= bus.query_y;
                norm_z <= bus.query_z;
                sum_r  <= '0;
            end else if (state == ISSUE) begin
                cnt <= cnt + ADDR_W'(1);
            end
        end
    end

    kz_valid_pipe #(
        .DEPTH (DEPTH),
        .IDX_W (ADDR_W)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.mem_rd_en),
        .in_index  (cnt),
        .pending   (pending),
        .pre_valid (pre_valid),
        .out_valid (out_valid),
        .out_index (out_index)
    );

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.mem_rd_en = (state == ISSUE);
    assign bus.mem_addr  = cnt;
    assign bus.kz_int_x  = int_x;
    assign bus.kz_int_y  = int_y;
    assign bus.kz_int_z  = int_z;
    assign bus.kz_norm_x = norm_x;
    assign bus.kz_norm_y = norm_y;
    assign bus.kz_norm_z = norm_z;
    assign bus.k_valid   = out_valid;
    assign bus.k_index   = out_index;
    assign bus.k_data    = data_r;
    assign bus.k_sum     = sum_r;

endmodule

// File: tb/tb_kz_sched.sv
// Scoreboard bench for kz_sched with an 8-cycle delay standing in for K_Z.
module tb_kz_sched;

    localparam int LAT = 8;

    typedef struct {
        int          cyc;
        int          idx;
        logic [31:0] data;
    } res_t;

    typedef struct {
        int          cyc;
        logic [47:0] sum;
    } done_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    kz_sched_if #(.DATA_WIDTH(16), .ADDR_W(8), .SUM_W(48)) bus ();

    kz_sched #(
        .DATA_WIDTH (16),
        .ADDR_W     (8),
        .N_MAX      (256),
        .KZ_LATENCY (LAT),
        .SUM_W      (48)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [15:0] mem [256];
    logic [15:0] dly [LAT];
    res_t        exp_q [$];
    done_t       done_q [$];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          rd_count = 0;
    int          rd_before;
    logic [15:0] exp_nx, exp_ny, exp_nz;

    assign bus.mem_x  = mem[bus.mem_addr];
    assign bus.mem_y  = 16'h0000;
    assign bus.mem_z  = 16'h0000;
    assign bus.kz_out = {{16{dly[LAT-1][15]}}, dly[LAT-1]};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        dly[0] <= bus.kz_int_x;
        for (int j = 1; j < LAT; j++) begin
            dly[j] <= dly[j-1];
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: every k_valid and done must match the next queued expectation, cycle included.
    always @(negedge clk) begin
        res_t  e;
        done_t d;
        if (rst_n === 1'b1) begin
            if (bus.k_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_k_valid: got k_valid=1 index %0d, expected none (cycle %0d)", bus.k_index, cyc);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("k_cycle", 64'(cyc), 64'(e.cyc));
                    checkOutput("k_index", 64'(bus.k_index), 64'(e.idx));
                    checkOutput("k_data", 64'(bus.k_data), 64'(e.data));
                end
            end
            if (bus.done) begin
                if (done_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
                end else begin
                    d = done_q.pop_front();
                    checkOutput("done_cycle", 64'(cyc), 64'(d.cyc));
                    checkOutput("done_sum", 64'(bus.k_sum), 64'(d.sum));
                end
            end
            if (bus.mem_rd_en) rd_count++;
        end
    end

    task automatic applyStimulus(input int n, input logic [15:0] qx, input logic [15:0] qy, input logic [15:0] qz);
        int     c0;
        int     v;
        longint s;
        @(negedge clk);
        c0 = cyc;
        bus.start      = 1'b1;
        bus.num_points = 9'(n);
        bus.query_x    = qx;
        bus.query_y    = qy;
        bus.query_z    = qz;
        exp_nx = qx;
        exp_ny = qy;
        exp_nz = qz;
        s = 0;
        for (int i = 0; i < n; i++) begin
            v = int'($signed(mem[i]));
            s += v;
            exp_q.push_back('{c0 + i + 3 + LAT, i % 256, 32'(v)});
        end
        done_q.push_back('{(n == 0) ? c0 + 1 : c0 + n + 3 + LAT, s[47:0]});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            if (bus.busy) begin
                checkOutput("norm_x", 64'(bus.kz_norm_x), 64'(exp_nx));
                checkOutput("norm_y", 64'(bus.kz_norm_y), 64'(exp_ny));
                checkOutput("norm_z", 64'(bus.kz_norm_z), 64'(exp_nz));
            end
            if (bus.done) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("[TB] FAIL done_timeout: got no done within %0d cycles, expected done=1", budget);
        end
    endtask

    task automatic checkResetValues();
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_done", 64'(bus.done), 64'd0);
        checkOutput("rst_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
        checkOutput("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        checkOutput("rst_int_x", 64'(bus.kz_int_x), 64'd0);
        checkOutput("rst_norm_x", 64'(bus.kz_norm_x), 64'd0);
        checkOutput("rst_norm_z", 64'(bus.kz_norm_z), 64'd0);
        checkOutput("rst_k_valid", 64'(bus.k_valid), 64'd0);
        checkOutput("rst_k_index", 64'(bus.k_index), 64'd0);
        checkOutput("rst_k_data", 64'(bus.k_data), 64'd0);
        checkOutput("rst_k_sum", 64'(bus.k_sum), 64'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.num_points = '0;
        bus.query_x    = '0;
        bus.query_y    = '0;
        bus.query_z    = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        repeat (3) @(negedge clk);
        checkResetValues();
        rst_n = 1'b1;

        // Run cut off by reset during ISSUE leaves nothing behind.
        for (int i = 0; i < 10; i++) mem[i] = 16'(i * 3 + 1);
        applyStimulus(10, 16'd11, 16'd22, 16'd33);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        done_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        checkResetValues();
        repeat (LAT + 15) @(negedge clk);
        checkOutput("idle_after_reset", 64'(bus.busy), 64'd0);

        mem[0] = 16'd100;
        mem[1] = 16'hFFF9;
        mem[2] = 16'd300;
        mem[3] = 16'd12;
        applyStimulus(4, 16'd5, 16'hFFFA, 16'd7);
        waitDone(4 + LAT + 20);
        checkOutput("basic_sum", 64'(bus.k_sum), 64'd405);

        // Empty run started the cycle after the previous done.
        rd_before = rd_count;
        applyStimulus(0, 16'd1, 16'd2, 16'd3);
        waitDone(10);
        checkOutput("empty_no_reads", 64'(rd_count), 64'(rd_before));
        checkOutput("empty_sum", 64'(bus.k_sum), 64'd0);

        mem[0] = 16'd3;
        mem[1] = 16'd1;
        mem[2] = 16'd4;
        mem[3] = 16'd1;
        mem[4] = 16'd5;
        applyStimulus(5, 16'h0100, 16'h0200, 16'h0300);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.num_points = 9'd1;
        bus.query_x    = 16'd99;
        bus.query_y    = 16'd99;
        bus.query_z    = 16'd99;
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(5 + LAT + 20);
        checkOutput("ignore_sum", 64'(bus.k_sum), 64'd14);
        bus.start      = 1'b1;
        bus.num_points = 9'd2;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("done_start_ignored", 64'(bus.busy), 64'd0);

        for (int i = 0; i < 256; i++) mem[i] = 16'(i);
        applyStimulus(256, 16'd1, 16'd1, 16'd1);
        waitDone(256 + LAT + 20);
        checkOutput("full_sum", 64'(bus.k_sum), 64'd32640);
        checkOutput("full_last_index", 64'(bus.k_index), 64'd255);

        mem[0] = 16'hFFFF;
        mem[1] = 16'hFFFF;
        mem[2] = 16'hFFFF;
        applyStimulus(3, 16'h8000, 16'h8000, 16'h8000);
        waitDone(3 + LAT + 20);
        checkOutput("neg_sum", 64'(bus.k_sum), 64'h0000_FFFF_FFFF_FFFD);

        repeat (5) @(negedge clk);
        checkOutput("queues_drained", 64'(exp_q.size() + done_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
